// File: rtl/mod_counter_pkg.sv
// Shared constants for the programmable-modulus counter cascade.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_WIDTH  = 4;

endpackage

// File: rtl/mod_counter_stage.sv
// One programmable-modulus digit: up/down step, clamped parallel load, terminal detect.
module mod_counter_stage
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] top_val;
  logic             full_range;
  logic             out_of_range;
  logic             tc_up;
  logic             tc_down;

  // A zero modulus selects the full 0..2^WIDTH-1 range.
  assign full_range   = (modulus == '0);
  assign top_val      = full_range ? '1 : modulus - WIDTH'(1);
  assign out_of_range = !full_range && (value_q >= modulus);

  // Stale out-of-range values count as terminal so they wrap cleanly on the next step.
  assign tc_up   = (value_q >= top_val);
  assign tc_down = (value_q == '0) || out_of_range;
  assign tc      = (up_down == DIR_UP) ? tc_up : tc_down;
  assign value   = value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (full_range || (load_value < modulus)) ? load_value : '0;
    end else if (step) begin
      if (up_down == DIR_UP) begin
        value_d = tc_up ? '0 : value_q + WIDTH'(1);
      end else begin
        value_d = tc_down ? top_val : value_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/mod_counter_cascade.sv
// Chain of programmable-modulus digits with ripple enable and a registered full-wrap pulse.
module mod_counter_cascade
  import mod_counter_pkg::*;
#(
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned WIDTH  = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [STAGES*WIDTH-1:0] load_value,
  input  logic [STAGES*WIDTH-1:0] modulus,
  output logic [STAGES*WIDTH-1:0] Q,
  output logic [STAGES-1:0]       stage_tc,
  output logic                    carry_out
);

  logic [STAGES-1:0] step;
  logic              advance;
  logic              carry_q;
  logic              carry_d;

  // Load has priority over counting, so no stage steps on a load edge.
  assign advance = enable && !load;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign step[i] = advance;
    end else begin : g_rest
      assign step[i] = step[i-1] && stage_tc[i-1];
    end

    mod_counter_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .step      (step[i]),
      .up_down   (up_down),
      .load      (load),
      .load_value(load_value[i*WIDTH +: WIDTH]),
      .modulus   (modulus[i*WIDTH +: WIDTH]),
      .value     (Q[i*WIDTH +: WIDTH]),
      .tc        (stage_tc[i])
    );
  end

  assign carry_d   = advance && (&stage_tc);
  assign carry_out = carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Self-checking bench for mod_counter_cascade (3 stages x 4 bits) against a digit-array model.
module tb_mod_counter_cascade;

  localparam int unsigned NS = 3;
  localparam int unsigned W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              up_down;
  logic              load;
  logic [NS*W-1:0]   load_value;
  logic [NS*W-1:0]   modulus;
  logic [NS*W-1:0]   Q;
  logic [NS-1:0]     stage_tc;
  logic              carry_out;

  int errors = 0;
  int checks = 0;

  int mv[NS];
  int mcarry;

  typedef struct {
    logic            rst;
    logic            en;
    logic            ud;
    logic            ld;
    logic [NS*W-1:0] lv;
    logic [NS*W-1:0] md;
    logic [NS*W-1:0] eq;
    logic            ec;
  } vec_t;

  vec_t tbl[13];

  mod_counter_cascade #(.STAGES(NS), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .up_down   (up_down),
    .load      (load),
    .load_value(load_value),
    .modulus   (modulus),
    .Q         (Q),
    .stage_tc  (stage_tc),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  function automatic int digit(input logic [NS*W-1:0] v, input int i);
    logic [W-1:0] d;
    d = v[i*W +: W];
    return int'(d);
  endfunction

  // Effective modulus as a plain number: 0 means 16.
  function automatic int eff_mod(input int i);
    int m;
    m = digit(modulus, i);
    return (m == 0) ? 16 : m;
  endfunction

  function automatic bit model_tc(input int i);
    int m;
    m = eff_mod(i);
    if (up_down) return mv[i] >= m - 1;
    return (mv[i] == 0) || (mv[i] >= m);
  endfunction

  function automatic logic [NS*W-1:0] model_q();
    logic [NS*W-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++) r[i*W +: W] = W'(mv[i]);
    return r;
  endfunction

  function automatic logic [NS-1:0] model_tcs();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = model_tc(i);
    return r;
  endfunction

  // Advance the reference by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit lower_all;
    bit tcs[NS];
    int m;
    for (int i = 0; i < NS; i++) tcs[i] = model_tc(i);
    if (reset) begin
      for (int i = 0; i < NS; i++) mv[i] = 0;
      mcarry = 0;
    end else if (load) begin
      for (int i = 0; i < NS; i++) begin
        m = eff_mod(i);
        mv[i] = (digit(load_value, i) < m) ? digit(load_value, i) : 0;
      end
      mcarry = 0;
    end else if (enable) begin
      lower_all = 1;
      for (int i = 0; i < NS; i++) begin
        if (lower_all) begin
          m = eff_mod(i);
          if (up_down) mv[i] = (mv[i] + 1 >= m) ? 0 : mv[i] + 1;
          else         mv[i] = (mv[i] == 0 || mv[i] >= m) ? m - 1 : mv[i] - 1;
        end
        lower_all = lower_all && tcs[i];
      end
      mcarry = lower_all ? 1 : 0;
    end else begin
      mcarry = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_q", int'(Q), int'(model_q()));
    chk("model_carry", int'(carry_out), mcarry);
    chk("model_tc", int'(stage_tc), int'(model_tcs()));
  endtask

  task automatic drive(input logic r, input logic e, input logic ud, input logic l,
                       input logic [NS*W-1:0] lv, input logic [NS*W-1:0] md);
    reset = r; enable = e; up_down = ud; load = l; load_value = lv; modulus = md;
  endtask

  initial begin
    for (int i = 0; i < NS; i++) mv[i] = 0;
    mcarry = 0;
    drive(1, 0, 1, 0, '0, 12'hA6A);

    //            rst en ud ld  lv       md       eq       ec
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 12'hA6A, 12'h000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 12'hA6A, 12'h000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'hA6A, 12'h959, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'hA6A, 12'h958, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 12'hA6A, 12'h000, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h374, 12'hA6A, 12'h304, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'hA6A, 12'h305, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'hA6A, 12'h305, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 12'hA6A, 12'h000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h958, 12'hA6A, 12'h958, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'hA6A, 12'h959, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'hA6A, 12'h000, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'hA6A, 12'h000, 1'b0};

    @(negedge clk);
    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].rst, tbl[v].en, tbl[v].ud, tbl[v].ld, tbl[v].lv, tbl[v].md);
      tick();
      chk($sformatf("vec%0d_q", v), int'(Q), int'(tbl[v].eq));
      chk($sformatf("vec%0d_carry", v), int'(carry_out), int'(tbl[v].ec));
    end

    // Full 600-step up count from reset.
    drive(1, 0, 1, 0, '0, 12'hA6A);
    tick();
    drive(0, 1, 1, 0, '0, 12'hA6A);
    for (int e = 1; e <= 600; e++) begin
      tick();
      if (e == 9)   chk("up9_q", int'(Q), 12'h009);
      if (e == 10)  chk("up10_q", int'(Q), 12'h010);
      if (e == 600) chk("up600_q", int'(Q), 12'h000);
      chk("up_carry", int'(carry_out), (e == 600) ? 1 : 0);
    end
    tick();
    chk("up601_carry", int'(carry_out), 0);

    // Modulus shrink under a stale digit, then hold.
    drive(0, 0, 1, 1, 12'h008, 12'hA6A);
    tick();
    drive(0, 1, 1, 0, '0, 12'hA65);
    tick();
    chk("modchg_q", int'(Q), 12'h010);
    drive(0, 0, 1, 0, '0, 12'hA65);
    for (int c = 0; c < 20; c++) tick();
    chk("hold_q", int'(Q), 12'h010);

    // All moduli 1: counter pinned at zero, carry continuous.
    drive(0, 0, 1, 1, 12'h000, 12'h111);
    tick();
    drive(0, 1, 1, 0, '0, 12'h111);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("m1_q", int'(Q), 0);
      chk("m1_carry", int'(carry_out), 1);
      chk("m1_tc", int'(stage_tc), 3'b111);
    end

    // Full-range stage 0.
    drive(0, 1, 1, 0, '0, 12'h110);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("m0_q", int'(Q), c % 16);
    end

    // Randomised traffic against the model.
    drive(0, 0, 1, 1, '0, 12'hA6A);
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      load    = ($urandom_range(0, 19) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up_down = ~up_down;
      load_value = 12'($urandom);
      if ($urandom_range(0, 49) == 0) modulus = 12'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_counter_cascade.md
# mod_counter_cascade

Parametrised chain of programmable-modulus counter stages for multi-digit counting: BCD displays, hh:mm:ss timekeeping, mixed-radix event counters. Each stage has its own runtime modulus. Stage 0 is least significant. Each stage advances only when every lower stage is at its terminal value. The block supports up/down counting, synchronous parallel load and a registered chain wrap pulse. It replaces single fixed-modulus counters wherever more than one digit, or a runtime modulus, is needed.

## Interface
Parameters:
- STAGES, 4, number of counter stages (≥1)
- WIDTH, 4, bits per stage

Ports:
- Clocking: one clock; reset is synchronous and active-high
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  count request for stage 0, one step per cycle
- up_down  input  1  1 = count up, 0 = count down
- load  input  1  synchronous parallel load
- load_value  input  STAGES*WIDTH  per-stage load values; stage i in bits [i*WIDTH +: WIDTH]
- modulus  input  STAGES*WIDTH  per-stage modulus M_i, same packing
- Q  output  STAGES*WIDTH  per-stage count values, same packing
- stage_tc  output  STAGES  combinational; bit i high when stage i is at its terminal value for the current direction
- carry_out  output  1  registered one-cycle pulse after a full-chain wrap

## Operation
- Each stage counts in the range 0..M_i−1.
- M_i = 0 means full range, 0..2^WIDTH−1.
- M_i = 1 means the stage is always 0 and its stage_tc is always 1.
- Terminal value when counting up is M_i−1; when counting down it is 0.
- Stage i steps when enable is high and stage_tc[j] = 1 for all j < i.
- Up step:
  - value ≥ M_i−1 → 0 (this also covers out-of-range values)
  - otherwise value+1
- Down step:
  - value = 0 or value ≥ M_i → M_i−1
  - otherwise value−1
- Load: stage i takes load_value_i if it is < M_i (any value when M_i = 0); otherwise it takes 0.
- Priority per edge: reset > load > enable. When load and enable are both high, load wins and nothing steps.
- enable low and load low: all stages hold.
- A change to modulus takes effect on the next step. A stale value is not corrected until that stage next steps or is loaded.
- Full-chain wrap: an edge with enable=1, load=0, reset=0 and all stage_tc = 1.
  - carry_out = 1 for exactly the following cycle.
  - Back-to-back wraps (e.g. all M_i = 1) give carry_out high continuously.
- up_down may change on any cycle. It is sampled on each edge, and stage_tc follows it combinationally.

## Timing
- Reset values: Q = 0, carry_out = 0. After reset, stage_tc reflects 0 versus the current modulus and direction.
- Q updates on the rising edge where the step or load is sampled, so latency from enable to Q is 1 cycle.
- carry_out is registered. It rises on the same edge on which Q wraps to all-terminal-opposite (up: all 0; down: all M_i−1).
- stage_tc and the ripple-enable chain are combinational within the cycle. There are no multi-cycle paths.
- Reset asserted mid-count, with or without load or enable, clears Q and carry_out on that edge.

## Structure
- Shared package mod_counter_pkg:
  - direction constants DIR_UP = 1'b1, DIR_DOWN = 1'b0
  - default STAGES and WIDTH localparams
- Sub-module mod_counter_stage (one per stage, generated):
  - inputs: clk, reset, step, up_down, load, load_value, modulus
  - outputs: value, tc
- The top level holds:
  - the ripple-enable AND chain
  - the wrap detect
  - the carry_out register

## Test plan
Common config: STAGES=3, WIDTH=4; modulus stage0=10, stage1=6, stage2=10 (chain range 0–599) unless noted.
- Reset: assert reset 2 cycles with enable=1, load=1 → Q=0, carry_out=0.
- Up count with enable held:
  - after 9 edges Q = {0,0,9}
  - after 10 edges Q = {0,1,0}
  - after 600 edges Q = {0,0,0}, with carry_out high only in cycle 601
- Down count from 0: one enable edge → Q = {9,5,9} and carry_out = 1 for one cycle; next edge → {9,5,8}.
- Load:
  - load_value = {3,7,4} with load=1 and enable=1 → Q = {3,0,4} (stage1 7 ≥ 6 loads 0; no step)
  - next edge with enable → {3,0,5}
- Modulus change and hold:
  - stage0 at 8, change M_0 to 5, step up → stage0 = 0 and stage1 increments
  - enable=0 for 20 cycles → Q unchanged
- Edge moduli: set all M_i = 1 with enable held → Q stays 0 and carry_out stays high. Set M_0 = 0 → stage0 counts 0–15.
